hazard_stall_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage semiMIPS core. It resolves by stalling the hazards that the ALU/memory bypass network cannot resolve.
- Hazards handled: load-use, branch-in-ID operand dependencies, and HI/LO access while the multi-cycle mul/div unit is busy.
- Drives PC write enable, IF/ID write enable, ID/EX bubble insertion and IF/ID flush on taken branches.
- Sits beside the forwarding logic and observes the same IF/ID, ID/EX and EX/MEM pipeline register fields.

---
 rtl/hazard_stall_unit.sv | 77 +++++++
 tb/tb_hazard_stall_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch / mul-div stall and flush control; optional stall counter via HAZARD_STALL_CNT_EN
module hazard_stall_unit #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ifidrs,
  input  logic [4:0] ifidrt,
  input  logic       ifidusesrs,
  input  logic       ifidusesrt,
  input  logic       ifidbranch,
  input  logic       ifidhilo,
  input  logic       idexmemrd,
  input  logic       idexregwr,
  input  logic [4:0] idexregmuxout,
  input  logic       idexmuldiv,
  input  logic       exmemmemrd,
  input  logic [4:0] exmemregmuxout,
  input  logic       branchtaken,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0] stallcnt,
`endif
  output logic       pcwr,
  output logic       ifidwr,
  output logic       idexbubble,
  output logic       ifidflush,
  output logic       muldivbusy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t fsm;
  logic [CNT_W-1:0] cnt;
  logic m_ex, m_mem, stall;
  // operand match against EX/MEM destinations, then the four stall terms
  always_comb begin
    m_ex  = idexregmuxout != 5'd0 &&
            ((ifidusesrs && idexregmuxout == ifidrs) || (ifidusesrt && idexregmuxout == ifidrt));
    m_mem = exmemregmuxout != 5'd0 &&
            ((ifidusesrs && exmemregmuxout == ifidrs) || (ifidusesrt && exmemregmuxout == ifidrt));
    stall = (idexmemrd && m_ex) ||
            (ifidbranch && idexregwr && !idexmemrd && m_ex) ||
            (ifidbranch && exmemmemrd && m_mem) ||
            (fsm == BUSY && ifidhilo);
  end
  // pipeline controls; reset holds the pipe frozen with a bubble
  always_comb begin
    pcwr       = !rst && !stall;
    ifidwr     = !rst && !stall;
    idexbubble = rst || stall;
    ifidflush  = !rst && branchtaken && !stall;
    muldivbusy = !rst && fsm == BUSY;
  end
  // mul/div countdown; a launch while busy is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      cnt <= '0;
    end else if (fsm == IDLE) begin
      if (idexmuldiv) begin
        fsm <= BUSY;
        cnt <= CNT_W'(MULDIV_LAT - 1);
      end
    end else if (cnt == CNT_W'(1)) begin
      fsm <= IDLE;
      cnt <= '0;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  // free-running count of stalled cycles, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) stallcnt <= '0;
    else if (stall) stallcnt <= stallcnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vectors for hazard_stall_unit with MULDIV_LAT=4
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] ifidrs, ifidrt, idexregmuxout, exmemregmuxout;
  logic ifidusesrs, ifidusesrt, ifidbranch, ifidhilo;
  logic idexmemrd, idexregwr, idexmuldiv, exmemmemrd, branchtaken;
  logic pcwr, ifidwr, idexbubble, ifidflush, muldivbusy;
  logic [4:0] o;
  int n_chk = 0;
  int n_pass = 0;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stallcnt;
`endif
  localparam logic [4:0] RUN   = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] FLUSH = 5'b11010;
  localparam logic [4:0] BSTL  = 5'b00101;
  hazard_stall_unit #(.MULDIV_LAT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidusesrs(ifidusesrs), .ifidusesrt(ifidusesrt),
    .ifidbranch(ifidbranch), .ifidhilo(ifidhilo),
    .idexmemrd(idexmemrd), .idexregwr(idexregwr), .idexregmuxout(idexregmuxout),
    .idexmuldiv(idexmuldiv), .exmemmemrd(exmemmemrd), .exmemregmuxout(exmemregmuxout),
    .branchtaken(branchtaken),
`ifdef HAZARD_STALL_CNT_EN
    .stallcnt(stallcnt),
`endif
    .pcwr(pcwr), .ifidwr(ifidwr), .idexbubble(idexbubble),
    .ifidflush(ifidflush), .muldivbusy(muldivbusy)
  );
  always #5 clk = ~clk;
  assign o = {pcwr, ifidwr, idexbubble, ifidflush, muldivbusy};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic at(input string tag, input logic [4:0] exp);
    @(negedge clk);
    chk(tag, {27'd0, o}, {27'd0, exp});
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {ifidrs, ifidrt, idexregmuxout, exmemregmuxout} = '0;
    {ifidusesrs, ifidusesrt, ifidbranch, ifidhilo} = '0;
    {idexmemrd, idexregwr, idexmuldiv, exmemmemrd, branchtaken} = '0;
  endtask
  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    at("reset", STALL);
    branchtaken = 1'b1;
    at("reset_no_flush", STALL);
    rst = 1'b0;
    branchtaken = 1'b0;
    at("idle", RUN);
    idexmemrd = 1'b1; idexregmuxout = 5'd5; ifidrs = 5'd5; ifidusesrs = 1'b1;
    at("load_use_rs", STALL);
    idexregmuxout = 5'd0; ifidrs = 5'd0;
    at("load_use_r0", RUN);
    idexregmuxout = 5'd5; ifidrs = 5'd5; ifidusesrs = 1'b0;
    at("load_use_unused", RUN);
    clr();
    idexmemrd = 1'b1; idexregmuxout = 5'd9; ifidrt = 5'd9; ifidusesrt = 1'b1;
    at("load_use_rt", STALL);
    clr();
    ifidbranch = 1'b1; ifidrt = 5'd8; ifidusesrt = 1'b1;
    idexmemrd = 1'b1; idexregwr = 1'b1; idexregmuxout = 5'd8;
    at("br_load_c0", STALL);
    idexmemrd = 1'b0; idexregwr = 1'b0; idexregmuxout = 5'd0;
    exmemmemrd = 1'b1; exmemregmuxout = 5'd8;
    at("br_load_c1", STALL);
    exmemmemrd = 1'b0; exmemregmuxout = 5'd0;
    at("br_load_c2", RUN);
    exmemmemrd = 1'b1; exmemregmuxout = 5'd0; ifidrt = 5'd0;
    at("br_mem_r0", RUN);
    clr();
    ifidbranch = 1'b1; ifidrs = 5'd8; ifidusesrs = 1'b1;
    idexregwr = 1'b1; idexregmuxout = 5'd8;
    at("br_alu_c0", STALL);
    idexregwr = 1'b0; idexregmuxout = 5'd0;
    at("br_alu_c1", RUN);
    ifidbranch = 1'b0; idexregwr = 1'b1; idexregmuxout = 5'd8;
    at("alu_fwd_no_stall", RUN);
    ifidbranch = 1'b1; branchtaken = 1'b1;
    at("flush_blocked", STALL);
    idexregwr = 1'b0; idexregmuxout = 5'd0;
    at("flush_taken", FLUSH);
    clr();
    rst = 1'b1;
    at("rst_pulse", STALL);
    rst = 1'b0;
`ifdef HAZARD_STALL_CNT_EN
    chk("stallcnt_clear", stallcnt, 32'd0);
`endif
    idexmuldiv = 1'b1;
    at("md_launch", RUN);
    idexmuldiv = 1'b0; ifidhilo = 1'b1;
    for (int i = 1; i <= 3; i++) at($sformatf("md_busy%0d", i), BSTL);
`ifdef HAZARD_STALL_CNT_EN
    chk("stallcnt_md", stallcnt, 32'd3);
`endif
    at("md_release", RUN);
    ifidhilo = 1'b0;
    at("md_idle_nohilo", RUN);
    rst = 1'b1;
    at("rst_after_md", STALL);
    rst = 1'b0;
`ifdef HAZARD_STALL_CNT_EN
    chk("stallcnt_rst", stallcnt, 32'd0);
`endif
    idexmuldiv = 1'b1;
    at("rs_launch", RUN);
    ifidhilo = 1'b1;
    at("rs_relaunch_ignored", BSTL);
    idexmuldiv = 1'b0;
    at("rs_busy2", BSTL);
    at("rs_busy3", BSTL);
    at("rs_release", RUN);
    ifidhilo = 1'b0; idexmuldiv = 1'b1;
    at("mc_launch", RUN);
    idexmuldiv = 1'b0; ifidhilo = 1'b1;
    at("mc_busy1", BSTL);
    rst = 1'b1;
    at("mc_rst", STALL);
    rst = 1'b0;
    at("mc_after_rst", RUN);
    clr();
    idexmuldiv = 1'b1;
    at("multi_launch", RUN);
    idexmuldiv = 1'b0; ifidhilo = 1'b1;
    idexmemrd = 1'b1; idexregmuxout = 5'd3; ifidrs = 5'd3; ifidusesrs = 1'b1;
    at("multi_h1_h4", BSTL);
    clr();
    at("multi_busy_nohilo", 5'b11001);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
